lcd_cmd_sequencer: RTL and testbench
====================================

Name: lcd_cmd_sequencer

Overview:
Parametrised command-stream sequencer for the ILI9341 display path. It walks an arbitrary window of an external command ROM, chosen per run by base address and length, so init, loop and partial-update sequences share one engine. Each entry carries its own data, D/C and CS levels and a post-command delay. The block sits between the top-level display controller (start/done) and the SPI byte master (send/sent handshake).

Parameters:
DW, 8, command/data byte width
AW, 6, ROM address width (up to 2^AW entries)
DLYW, 8, per-entry delay field width
MIN_GAP, 8, mandatory idle cycles after every byte (min 1)
TICK_DIV, 1000, clk cycles per delay unit (min 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
i_start  in  1  start pulse, sampled only in IDLE
i_base  in  AW  first ROM address, latched on accepted start
i_len  in  AW+1  entry count, latched on accepted start
i_abort  in  1  abort request (level or pulse)
o_busy  out  1  high in any state except IDLE
o_done  out  1  1-cycle pulse: sequence completed
o_aborted  out  1  1-cycle pulse: sequence aborted
o_rom_addr  out  AW  ROM read address
i_rom_data  in  DW+2+DLYW  ROM word, valid 1 cycle after o_rom_addr changes
o_send  out  1  byte valid to SPI master, held until i_sent
o_data  out  DW  byte to send
o_dc  out  1  D/C line level
o_cs  out  1  CS line level (active low)
i_sent  in  1  1-cycle pulse from SPI master: byte shifted out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low. Every output is registered.
- Reset values: o_send=0, o_data=0, o_dc=1, o_cs=1, o_busy=0, o_done=0, o_aborted=0, o_rom_addr=0. All counters are cleared and the FSM enters IDLE.
- ROM entry layout: [DW-1:0] data, [DW] dc, [DW+1] cs, [DW+2 +: DLYW] delay in units of TICK_DIV cycles.
- IDLE: outputs sit at their reset values.
  - i_start with i_len!=0: latch base and len, set o_rom_addr=i_base, go to FETCH.
  - i_start with i_len==0: go straight to DONE.
- FETCH (2 cycles): cycle 1 waits for ROM latency; cycle 2 captures i_rom_data into the entry register and goes to SEND.
- SEND: o_send=1; o_data, o_dc and o_cs come from the entry register. Hold every output stable until i_sent, then go to GAP.
- GAP: o_send=0, o_data=0, o_dc and o_cs hold the entry values. Count MIN_GAP cycles.
  - On expiry: go to DELAY if the delay field is non-zero, otherwise to NEXT.
- DELAY: o_dc and o_cs still held. A prescaler counts TICK_DIV cycles per unit, for delay×TICK_DIV cycles in total. No multiplier is used.
- NEXT (1 cycle): decrement the remaining count.
  - Remaining count reaches 0: go to DONE.
  - Otherwise: o_rom_addr+1 (wraps modulo 2^AW), go to FETCH.
- DONE (1 cycle): o_done=1, o_dc=1, o_cs=1, then IDLE.
- Latency:
  - From accepted i_start to first o_send: 3 cycles.
  - From i_sent to next o_send with delay=0: MIN_GAP+4 cycles.
- Abort:
  - In FETCH, GAP, DELAY or NEXT: next state is ABORT.
  - In SEND: the request is remembered and takes effect on i_sent, so a byte is never cut mid-transfer.
  - ABORT (1 cycle): o_aborted=1, o_cs=1, o_dc=1, o_send=0, then IDLE. If abort and completion coincide, abort wins.
- Ignored inputs: i_start while busy; i_sent outside SEND.
- Reset asserted mid-sequence: immediate return to reset values, with no done or aborted pulse.
- Counters are sized to their maximum values: gap uses clog2(MIN_GAP+1) bits, prescaler uses clog2(TICK_DIV+1) bits, the delay counter uses DLYW bits, and the remaining count uses AW+1 bits.

Test Plan:
- Reset then idle: all outputs at their reset values; o_rom_addr=0 with no start.
- Base=4, len=3, ROM[4..6]={0x01/dc0, 0x11/dc0, 0x29/dc0}, delay=0, i_sent returned 2 cycles after each o_send: expect three o_send bursts with o_data 0x01, 0x11, 0x29 and o_dc=0, o_done exactly once, then o_busy=0.
- Delay field: entry with delay=2, TICK_DIV=10, MIN_GAP=8: expect i_sent to the next o_send = 8+20+4 = 32 cycles; o_cs stays at the entry level throughout.
- Wrap: base=62, len=3, AW=6: expect o_rom_addr sequence 62, 63, 0.
- Abort during SEND: i_abort while o_send=1 with i_sent 5 cycles later: expect o_send held until i_sent, then o_aborted for 1 cycle, no o_done, and o_cs=1.
- len=0 start: expect o_done 1 cycle after i_start with no o_send. A second i_start during busy is ignored and the latched base is unchanged.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// Walks a window of an external command ROM and hands each entry to the SPI byte master.
// After each byte it waits for a fixed idle gap and then for the entry's own delay.
module lcd_cmd_sequencer #(
   parameter int DW       = 8,
   parameter int AW       = 6,
   parameter int DLYW     = 8,
   parameter int MIN_GAP  = 8,
   parameter int TICK_DIV = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [AW-1:0]          i_base,
   input  logic [AW:0]            i_len,
   input  logic                   i_abort,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_aborted,
   output logic [AW-1:0]          o_rom_addr,
   input  logic [DW+2+DLYW-1:0]   i_rom_data,
   output logic                   o_send,
   output logic [DW-1:0]          o_data,
   output logic                   o_dc,
   output logic                   o_cs,
   input  logic                   i_sent
);

   localparam int EW = DW + 2 + DLYW;
   localparam int GW = $clog2(MIN_GAP + 1);
   localparam int PW = $clog2(TICK_DIV + 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH1 = 4'd1;
   localparam logic [3:0] S_FETCH2 = 4'd2;
   localparam logic [3:0] S_SEND   = 4'd3;
   localparam logic [3:0] S_GAP    = 4'd4;
   localparam logic [3:0] S_DELAY  = 4'd5;
   localparam logic [3:0] S_NEXT   = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;
   localparam logic [3:0] S_ABORT  = 4'd8;

   logic [3:0]      state, state_nx;
   logic [EW-1:0]   entry_q, entry_nx;
   logic [AW:0]     rem_q, rem_nx;
   logic [GW-1:0]   gap_q, gap_nx;
   logic [PW-1:0]   presc_q, presc_nx;
   logic [DLYW-1:0] dly_q, dly_nx;
   logic            pend_q, pend_nx;
   logic [AW-1:0]   addr_nx;
   logic [DW-1:0]   data_nx;
   logic            send_nx, dc_nx, cs_nx, busy_nx, done_nx, aborted_nx;
   logic [DLYW-1:0] ent_dly;

   assign ent_dly = entry_q[DW+2 +: DLYW];

   // Next-state and counter logic.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nx = state;
      entry_nx = entry_q;
      rem_nx   = rem_q;
      gap_nx   = gap_q;
      presc_nx = presc_q;
      dly_nx   = dly_q;
      pend_nx  = pend_q;
      addr_nx  = o_rom_addr;

      case (state)
         S_IDLE: begin
            pend_nx = 1'b0;
            if (i_start) begin
               if (i_len != '0) begin
                  state_nx = S_FETCH1;
                  addr_nx  = i_base;
                  rem_nx   = i_len;
               end else begin
                  state_nx = S_DONE;
               end
            end
         end

         S_FETCH1: state_nx = i_abort ? S_ABORT : S_FETCH2;

         S_FETCH2: begin
            if (i_abort) begin
               state_nx = S_ABORT;
            end else begin
               entry_nx = i_rom_data;
               state_nx = S_SEND;
            end
         end

         // An abort here is parked until the byte has left, never cutting a transfer.
         S_SEND: begin
            if (i_sent) begin
               pend_nx = 1'b0;
               if (pend_q || i_abort) begin
                  state_nx = S_ABORT;
               end else begin
                  state_nx = S_GAP;
                  gap_nx   = GW'(MIN_GAP);
               end
            end else if (i_abort) begin
               pend_nx = 1'b1;
            end
         end

         S_GAP: begin
            if (i_abort) begin
               state_nx = S_ABORT;
            end else if (gap_q == GW'(1)) begin
               if (ent_dly != '0) begin
                  state_nx = S_DELAY;
                  dly_nx   = ent_dly;
                  presc_nx = PW'(TICK_DIV);
               end else begin
                  state_nx = S_NEXT;
               end
            end else begin
               gap_nx = gap_q - GW'(1);
            end
         end

         // Prescaler reloads per unit, so delay*TICK_DIV cycles elapse without a multiplier.
         S_DELAY: begin
            if (i_abort) begin
               state_nx = S_ABORT;
            end else if (presc_q == PW'(1)) begin
               if (dly_q == DLYW'(1)) begin
                  state_nx = S_NEXT;
               end else begin
                  dly_nx   = dly_q - DLYW'(1);
                  presc_nx = PW'(TICK_DIV);
               end
            end else begin
               presc_nx = presc_q - PW'(1);
            end
         end

         S_NEXT: begin
            if (i_abort) begin
               state_nx = S_ABORT;
            end else begin
               rem_nx = rem_q - 1'b1;
               if (rem_q == (AW+1)'(1)) begin
                  state_nx = S_DONE;
               end else begin
                  addr_nx  = o_rom_addr + AW'(1);
                  state_nx = S_FETCH1;
               end
            end
         end

         S_DONE:  state_nx = S_IDLE;
         S_ABORT: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      if (state_nx == S_IDLE) addr_nx = '0;
   end

   // Output values are derived from the next state so every output comes straight off a flop.
   always_comb begin
      send_nx    = 1'b0;
      data_nx    = '0;
      dc_nx      = o_dc;
      cs_nx      = o_cs;
      busy_nx    = 1'b1;
      done_nx    = 1'b0;
      aborted_nx = 1'b0;

      case (state_nx)
         S_IDLE: begin
            busy_nx = 1'b0;
            dc_nx   = 1'b1;
            cs_nx   = 1'b1;
         end
         S_SEND: begin
            send_nx = 1'b1;
            data_nx = entry_nx[DW-1:0];
            dc_nx   = entry_nx[DW];
            cs_nx   = entry_nx[DW+1];
         end
         S_DONE: begin
            done_nx = 1'b1;
            dc_nx   = 1'b1;
            cs_nx   = 1'b1;
         end
         S_ABORT: begin
            aborted_nx = 1'b1;
            dc_nx      = 1'b1;
            cs_nx      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         entry_q    <= '0;
         rem_q      <= '0;
         gap_q      <= '0;
         presc_q    <= '0;
         dly_q      <= '0;
         pend_q     <= 1'b0;
         o_rom_addr <= '0;
         o_send     <= 1'b0;
         o_data     <= '0;
         o_dc       <= 1'b1;
         o_cs       <= 1'b1;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_aborted  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state      <= state_nx;
         entry_q    <= entry_nx;
         rem_q      <= rem_nx;
         gap_q      <= gap_nx;
         presc_q    <= presc_nx;
         dly_q      <= dly_nx;
         pend_q     <= pend_nx;
         o_rom_addr <= addr_nx;
         o_send     <= send_nx;
         o_data     <= data_nx;
         o_dc       <= dc_nx;
         o_cs       <= cs_nx;
         o_busy     <= busy_nx;
         o_done     <= done_nx;
         o_aborted  <= aborted_nx;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: a timeline model expands each run into expected per-cycle
// outputs, compared every cycle, plus literal expectations for latencies and byte order.
module tb_lcd_cmd_sequencer;

   localparam int DW       = 8;
   localparam int AW       = 6;
   localparam int DLYW     = 8;
   localparam int MIN_GAP  = 8;
   localparam int TICK_DIV = 10;

   typedef struct packed {
      logic       send;
      logic [7:0] data;
      logic       dc;
      logic       cs;
      logic       busy;
      logic       done;
      logic       aborted;
      logic [5:0] addr;
   } row_t;

   logic          clk, rst;
   logic          i_start, i_abort, i_sent;
   logic [5:0]    i_base;
   logic [6:0]    i_len;
   logic          o_busy, o_done, o_aborted, o_send, o_dc, o_cs;
   logic [5:0]    o_rom_addr;
   logic [7:0]    o_data;
   logic [17:0]   i_rom_data;

   logic [17:0]   rom [64];
   logic [5:0]    addr_d;
   row_t          exp_q[$];
   int            errors = 0, checks = 0, cyc = 0;
   int            sent_lat = 2, sent_cnt = 0;
   int            sends[$], s_addrs[$], s_cycs[$], sent_cycs[$];
   int            done_cnt, ab_cnt, done_cyc, ab_cyc, start_cyc;
   logic          send_prev = 1'b0;

   lcd_cmd_sequencer #(
      .DW(DW), .AW(AW), .DLYW(DLYW), .MIN_GAP(MIN_GAP), .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_base(i_base), .i_len(i_len),
      .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
      .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_send(o_send), .o_data(o_data),
      .o_dc(o_dc), .o_cs(o_cs), .i_sent(i_sent)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic row_t mk_row(input logic send, input logic [7:0] data, input logic dc,
                                   input logic cs, input logic busy, input logic done,
                                   input logic aborted, input logic [5:0] addr);
      row_t r;
      r.send = send; r.data = data; r.dc = dc; r.cs = cs;
      r.busy = busy; r.done = done; r.aborted = aborted; r.addr = addr;
      return r;
   endfunction

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Synchronous ROM: data for an address appears one cycle after the address changes.
   initial forever begin
      @(posedge clk); #1;
      i_rom_data = rom[addr_d];
      addr_d     = o_rom_addr;
   end

   // SPI master stand-in: pulses i_sent sent_lat cycles after o_send rises.
   initial forever begin
      @(posedge clk); #1;
      i_sent = 1'b0;
      if (o_send) begin
         if (sent_cnt == sent_lat) begin
            i_sent   = 1'b1;
            sent_cnt = 0;
         end else begin
            sent_cnt++;
         end
      end else begin
         sent_cnt = 0;
      end
   end

   // Timeline model: row 0 is the cycle i_start is high; each later row is one clock.
   task automatic plan_run(input int base, input int len, input int slat, input int abort_at);
      int         t, addr, hold;
      logic       dc_h, cs_h;
      logic [17:0] w;
      bit         pend;
      exp_q.push_back(mk_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
      t = 1;
      if (len == 0) begin
         exp_q.push_back(mk_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0));
         return;
      end
      dc_h = 1'b1; cs_h = 1'b1; addr = base;
      for (int e = 0; e < len; e++) begin
         w = rom[addr];
         for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk_row(1'b0, 8'h00, dc_h, cs_h, 1'b1, 1'b0, 1'b0, 6'(addr)));
            if (t == abort_at) begin
               exp_q.push_back(mk_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'(addr)));
               return;
            end
            t++;
         end
         dc_h = w[8]; cs_h = w[9]; pend = 1'b0;
         for (int k = 0; k <= slat; k++) begin
            exp_q.push_back(mk_row(1'b1, w[7:0], dc_h, cs_h, 1'b1, 1'b0, 1'b0, 6'(addr)));
            if (t == abort_at) pend = 1'b1;
            t++;
         end
         if (pend) begin
            exp_q.push_back(mk_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'(addr)));
            return;
         end
         hold = MIN_GAP + int'(w[17:10]) * TICK_DIV + 1;
         for (int k = 0; k < hold; k++) begin
            exp_q.push_back(mk_row(1'b0, 8'h00, dc_h, cs_h, 1'b1, 1'b0, 1'b0, 6'(addr)));
            if (t == abort_at) begin
               exp_q.push_back(mk_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'(addr)));
               return;
            end
            t++;
         end
         if (e == len - 1)
            exp_q.push_back(mk_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'(addr)));
         else
            addr = (addr + 1) % 64;
      end
   endtask

   // Per-cycle compare and event recorder, sampled on the falling edge.
   initial forever begin
      row_t got, exp;
      @(negedge clk);
      got = mk_row(o_send, o_data, o_dc, o_cs, o_busy, o_done, o_aborted, o_rom_addr);
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = mk_row(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      check($sformatf("cycle %0d outputs", cyc), 64'(got), 64'(exp));
      if (o_send && !send_prev) begin
         sends.push_back(int'(o_data));
         s_addrs.push_back(int'(o_rom_addr));
         s_cycs.push_back(cyc);
      end
      send_prev = o_send;
      if (i_sent) sent_cycs.push_back(cyc);
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_aborted) begin ab_cnt++; ab_cyc = cyc; end
   end

   task automatic clear_rec();
      sends.delete(); s_addrs.delete(); s_cycs.delete(); sent_cycs.delete();
      done_cnt = 0; ab_cnt = 0; done_cyc = -1; ab_cyc = -1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
   endtask

   task automatic run(input int base, input int len, input int slat,
                      input int abort_at, input int restart_at);
      int last;
      clear_rec();
      sent_lat = slat;
      last = 1;
      if (abort_at > last) last = abort_at;
      if (restart_at > last) last = restart_at;
      @(posedge clk); #1;
      i_start = 1'b1; i_base = 6'(base); i_len = 7'(len);
      start_cyc = cyc;
      plan_run(base, len, slat, abort_at);
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         i_abort = (c == abort_at);
         i_start = (c == restart_at);
         if (c == restart_at) begin
            i_base = 6'd20;
            i_len  = 7'd1;
         end
      end
      @(posedge clk); #1;
      i_abort = 1'b0; i_start = 1'b0;
      wait_drain();
   endtask

   initial begin
      for (int a = 0; a < 64; a++) rom[a] = '0;
      rom[4]  = {8'd0, 1'b0, 1'b0, 8'h01};
      rom[5]  = {8'd0, 1'b0, 1'b0, 8'h11};
      rom[6]  = {8'd0, 1'b0, 1'b0, 8'h29};
      rom[10] = {8'd2, 1'b0, 1'b1, 8'hA5};
      rom[11] = {8'd0, 1'b0, 1'b0, 8'h3C};
      rom[62] = {8'd0, 1'b0, 1'b1, 8'hB0};
      rom[63] = {8'd0, 1'b0, 1'b0, 8'hB1};
      rom[0]  = {8'd0, 1'b1, 1'b1, 8'hB2};
      addr_d = '0; i_rom_data = '0;
      rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_sent = 1'b0;
      i_base = '0; i_len = '0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("reset o_rom_addr", 64'(o_rom_addr), 64'd0);
      check("reset o_dc/o_cs", 64'({o_dc, o_cs}), 64'h3);
      check("reset busy/send", 64'({o_busy, o_send, o_done, o_aborted}), 64'h0);

      // Three commands, no delay.
      run(4, 3, 2, -1, -1);
      check("basic sends", 64'(sends.size()), 64'd3);
      check("basic byte0", 64'(qat(sends, 0)), 64'h01);
      check("basic byte1", 64'(qat(sends, 1)), 64'h11);
      check("basic byte2", 64'(qat(sends, 2)), 64'h29);
      check("basic done count", 64'(done_cnt), 64'd1);
      check("start to send", 64'(qat(s_cycs, 0) - start_cyc), 64'd3);
      check("sent to send", 64'(qat(s_cycs, 1) - qat(sent_cycs, 0)), 64'd12);
      check("basic busy after", 64'(o_busy), 64'd0);

      // Delay of 2 units on the first entry.
      run(10, 2, 2, -1, -1);
      check("delay sent to send", 64'(qat(s_cycs, 1) - qat(sent_cycs, 0)), 64'd32);
      check("delay byte1", 64'(qat(sends, 1)), 64'h3C);

      // Address wrap.
      run(62, 3, 2, -1, -1);
      check("wrap addr0", 64'(qat(s_addrs, 0)), 64'd62);
      check("wrap addr1", 64'(qat(s_addrs, 1)), 64'd63);
      check("wrap addr2", 64'(qat(s_addrs, 2)), 64'd0);
      check("wrap byte2", 64'(qat(sends, 2)), 64'hB2);

      // Abort while the byte is in flight.
      run(4, 3, 5, 4, -1);
      check("abort send count", 64'(sends.size()), 64'd1);
      check("abort pulses", 64'(ab_cnt), 64'd1);
      check("abort no done", 64'(done_cnt), 64'd0);
      check("abort after sent", 64'(ab_cyc - qat(sent_cycs, 0)), 64'd1);

      // Zero-length start.
      run(9, 0, 2, -1, -1);
      check("len0 done latency", 64'(done_cyc - start_cyc), 64'd1);
      check("len0 no send", 64'(sends.size()), 64'd0);

      // Second start while busy is ignored.
      run(4, 3, 2, -1, 5);
      check("restart addr0", 64'(qat(s_addrs, 0)), 64'd4);
      check("restart addr2", 64'(qat(s_addrs, 2)), 64'd6);
      check("restart done count", 64'(done_cnt), 64'd1);

      // Abort in the gap, then abort coinciding with the final NEXT.
      run(4, 3, 2, 7, -1);
      check("gap abort pulses", 64'(ab_cnt), 64'd1);
      run(4, 1, 2, 14, -1);
      check("last-next abort pulses", 64'(ab_cnt), 64'd1);
      check("last-next no done", 64'(done_cnt), 64'd0);

      // Reset in the middle of a run.
      clear_rec();
      sent_lat = 2;
      @(posedge clk); #1;
      i_start = 1'b1; i_base = 6'd4; i_len = 7'd3;
      plan_run(4, 3, 2, -1);
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (5) @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) @(posedge clk); #1;
      check("reset mid-run pulses", 64'(done_cnt + ab_cnt), 64'd0);
      check("reset mid-run busy", 64'(o_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
